// File: rtl/gpio_regfile_bridge.sv
// rtl/gpio_regfile_bridge.sv - GPIO command decoder: register file, debounced switches, switch-event counter
module gpio_regfile_bridge #(
  parameter int NB_GPIOS        = 32,
  parameter int NB_DATA         = 16,
  parameter int NB_SW           = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                 clock,
  input  logic                 i_reset_n,
  input  logic [NB_GPIOS-1:0]  i_gpo,
  input  logic [NB_SW-1:0]     i_sw,
  output logic [NB_GPIOS-1:0]  o_gpi,
  output logic [8*NB_DATA-1:0] o_regs,
  output logic [NB_SW-1:0]     o_sw_db
);

  localparam logic [7:0] OP_WRITE    = 8'h01;
  localparam logic [7:0] OP_READ     = 8'h02;
  localparam logic [7:0] OP_READ_SW  = 8'h03;
  localparam logic [7:0] OP_READ_CNT = 8'h04;
  localparam logic [7:0] OP_CLR_CNT  = 8'h05;

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Enable resets high so SYNC waits for a genuinely sampled low enable.
  localparam logic [NB_GPIOS-1:0] GPO_RST = {{(NB_GPIOS-24){1'b0}}, 1'b1, 23'b0};

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_EXEC, S_ACK} state_t;

  state_t              state, state_nxt;
  logic [NB_GPIOS-1:0] gpo_q;
  logic                en;
  logic [7:0]          op_q;
  logic [2:0]          addr_q;
  logic [NB_DATA-1:0]  data_q;
  logic [NB_DATA-1:0]  regs [8];
  logic [NB_DATA-1:0]  rdata;
  logic                err;
  logic                ack;
  logic [NB_DATA-1:0]  evt_cnt;
  logic                clr;
  logic [NB_SW-1:0]    sync1, sync2, db_nxt;
  logic [CW-1:0]       db_cnt [NB_SW];
  logic                sw_change;
  logic                unused_gpo_bits;

  assign en              = gpo_q[23];
  assign unused_gpo_bits = ^gpo_q[22:19];

  always_comb begin
    state_nxt = state;
    case (state)
      S_SYNC:  if (!en) state_nxt = S_IDLE;
      S_IDLE:  if (en) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_ACK;
      S_ACK:   if (!en) state_nxt = S_IDLE;
      default: state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= S_SYNC;
      gpo_q  <= GPO_RST;
      op_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      rdata  <= '0;
      err    <= 1'b0;
      ack    <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      gpo_q <= i_gpo;
      if (state == S_IDLE && en) begin
        op_q   <= gpo_q[31:24];
        addr_q <= gpo_q[18:16];
        data_q <= gpo_q[NB_DATA-1:0];
      end
      if (state == S_EXEC) begin
        ack <= 1'b1;
        err <= 1'b0;
        case (op_q)
          OP_WRITE:    regs[addr_q] <= data_q;
          OP_READ:     rdata <= regs[addr_q];
          OP_READ_SW:  rdata <= NB_DATA'(o_sw_db);
          OP_READ_CNT: rdata <= evt_cnt;
          OP_CLR_CNT:  rdata <= '0;
          default:     err <= 1'b1;
        endcase
      end
      if (state == S_ACK && !en) ack <= 1'b0;
    end
  end

  always_comb begin
    db_nxt = o_sw_db;
    for (int i = 0; i < NB_SW; i++) begin
      if (sync2[i] != o_sw_db[i] && db_cnt[i] == DB_MAX) db_nxt[i] = sync2[i];
    end
  end

  assign sw_change = |(db_nxt ^ o_sw_db);
  assign clr       = (state == S_EXEC) && (op_q == OP_CLR_CNT);

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1   <= '0;
      sync2   <= '0;
      o_sw_db <= '0;
      evt_cnt <= '0;
      for (int i = 0; i < NB_SW; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= i_sw;
      sync2   <= sync1;
      o_sw_db <= db_nxt;
      for (int i = 0; i < NB_SW; i++) begin
        if (sync2[i] != o_sw_db[i] && db_cnt[i] != DB_MAX) db_cnt[i] <= db_cnt[i] + 1'b1;
        else db_cnt[i] <= '0;
      end
      // Clear takes priority over a coincident switch event.
      if (clr) evt_cnt <= '0;
      else if (sw_change) evt_cnt <= evt_cnt + 1'b1;
    end
  end

  always_comb begin
    o_gpi                = '0;
    o_gpi[NB_GPIOS-1]    = ack;
    o_gpi[NB_GPIOS-2]    = err;
    o_gpi[NB_DATA-1:0]   = rdata;
  end

  for (genvar g = 0; g < 8; g++) begin : g_regs
    assign o_regs[g*NB_DATA +: NB_DATA] = regs[g];
  end

endmodule

// File: doc/gpio_regfile_bridge.md
# gpio_regfile_bridge

Command-decoding register file that sits between the MicroBlaze GPIO port and the board hardware on the KC705. It consumes the 32-bit GPIO output word and executes one command per four-phase handshake: register write/read, debounced DIP-switch read, or switch-event counter read/clear. It produces the 32-bit GPIO input word that returns acknowledge, error and read data to the processor. Register contents are also exported to drive LEDs and other application logic.

## Interface
- NB_GPIOS, 32, GPIO word width; fixed, other values unsupported
- NB_DATA, 16, register and read-data width
- NB_SW, 4, number of DIP switch inputs
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles before a switch change is accepted (1 ms at 100 MHz)
- clock  in  1  application clock, same domain as the MicroBlaze GPIO
- i_reset_n  in  1  asynchronous, active-low reset
- i_gpo  in  NB_GPIOS  command word from processor: [31:24] opcode, [23] enable, [18:16] address, [15:0] data
- i_sw  in  NB_SW  raw DIP switches, asynchronous to clock
- o_gpi  out  NB_GPIOS  status to processor: [31] ack, [30] err, [29:16] zero, [15:0] read data
- o_regs  out  8*NB_DATA  flattened register file, reg n at [n*NB_DATA +: NB_DATA]
- o_sw_db  out  NB_SW  debounced switch state

## Operation
- i_gpo registered once (gpo_q); FSM and decoder use only gpo_q.
- FSM states: SYNC, IDLE, EXEC, ACK.
  - SYNC (reset state): go to IDLE when gpo_q[23]=0; prevents executing a stale command after reset.
  - IDLE: if gpo_q[23]=1, latch opcode/address/data, go to EXEC.
  - EXEC: one cycle; perform command, clear err then set it if opcode is illegal, set ack; go to ACK.
  - ACK: hold ack=1; when gpo_q[23]=0, clear ack, go to IDLE.
- Opcodes:
  - 0x01 WRITE: reg[addr] <= data; read data unchanged.
  - 0x02 READ: read data <= reg[addr].
  - 0x03 READ_SW: read data <= zero-extended o_sw_db.
  - 0x04 READ_CNT: read data <= event counter.
  - 0x05 CLR_CNT: counter <= 0, read data <= 0.
  - any other: err=1, no state change, read data unchanged.
- Read data and err hold until the next EXEC.
- Switch path, per bit: 2-FF synchronizer, then debounce. A per-bit counter increments while the synchronized value differs from o_sw_db and resets to 0 when they match. When the counter reaches DEBOUNCE_CYCLES-1, o_sw_db takes the new value and the counter resets.
- Event counter: NB_DATA bits, wraps. Increments by 1 in every cycle where any o_sw_db bit changes; multiple bits changing in the same cycle count once.

## Timing
- Reset: state=SYNC, o_gpi=0, o_regs=0, o_sw_db=0, counter=0, synchronizers and debounce counters 0.
- Command latency: enable sampled at clock edge k; gpo_q at k; EXEC entered at k+1; ack and read data visible after edge k+2.
- Ack release: enable low sampled at edge m; ack=0 after edge m+1.
- Enable is level, not edge. Holding it high after ack executes nothing further. A new command needs enable low, then high again.
- Opcode, address and data changes during EXEC or ACK are ignored; fields are latched on the IDLE->EXEC transition.
- CLR_CNT and a switch change in the same cycle: the clear wins, counter=0.
- READ_CNT and a switch change in the same cycle: returns the pre-increment value.
- Counter 0xFFFF + 1 wraps to 0x0000.
- Switch latency from pin to o_sw_db: 2 + DEBOUNCE_CYCLES cycles, ±1 for input-sampling phase. A glitch shorter than DEBOUNCE_CYCLES causes no change.
- Reset asserted mid-command: everything returns to reset values immediately. A command still pending with enable high is not executed until enable goes low and then high again.

## Test plan
Use DEBOUNCE_CYCLES=8 on the bench.
- WRITE then READ: write addr 3 data 0xBEEF, then READ addr 3 -> o_gpi[15:0]=0xBEEF, ack=1, err=0, o_regs[63:48]=0xBEEF.
- Handshake timing: assert enable at edge k -> ack=1 after edge k+2; deassert enable -> ack=0 two edges later; enable held high -> exactly one execution.
- Illegal opcode 0x7F -> err=1, ack=1, all regs and read data unchanged; a following legal READ clears err.
- Debounce: toggle i_sw[2] 0->1 with 5-cycle glitches, then hold stable -> o_sw_db stays 0 during glitches, becomes 0x4 after 8 stable cycles; READ_SW -> 0x0004; READ_CNT -> 1.
- Counter edges: preset counter to 0xFFFF via 0xFFFF switch events, one more event -> READ_CNT=0x0000; CLR_CNT in the same cycle as a switch change -> counter=0.
- Reset mid-command: assert i_reset_n=0 while in ACK with enable high -> o_gpi=0, o_regs=0; release reset with enable still high -> no execution until enable drops and rises again.
